uart_bus_master: RTL and testbench
==================================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 65535, meaning max cycles mem_valid is held without mem_ready before abort (1..65535).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_byte  input  8  byte from UART receiver.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe, rx_byte valid.
REQ-006 SHALL have port tx_byte  output  8  response byte to UART transmitter.
REQ-007 SHALL have port tx_valid  output  1  tx_byte valid, held until accepted.
REQ-008 SHALL have port tx_ready  input  1  transmitter accepts tx_byte when high with tx_valid.
REQ-009 SHALL have ports mem_valid output 1, mem_ready input 1, mem_addr output 32, mem_wdata output 32, mem_wstrb output 4, mem_rdata input 32: native bus initiator side.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, ADDR, DATA, BUS, RESP.
REQ-012 IDLE: rx_valid with rx_byte 0x57 ('W') -> ADDR, write flag set; 0x52 ('R') -> ADDR, write flag clear; any other byte ignored, stay IDLE.
REQ-013 ADDR: collect 4 bytes MSB first into mem_addr via 2-bit counter; after 4th byte -> DATA if write, else BUS.
REQ-014 DATA: collect 4 bytes MSB first into mem_wdata; after 4th byte -> BUS.
REQ-015 rx_valid SHALL be ignored in BUS and RESP (bytes dropped, no state change).
REQ-016 BUS: mem_valid SHALL be 1, mem_wstrb 4'hF for write and 4'h0 for read; mem_addr/mem_wdata/mem_wstrb SHALL be stable while mem_valid is 1.
REQ-017 On the cycle mem_ready is sampled 1 in BUS, SHALL capture mem_rdata (read), deassert mem_valid next cycle, go to RESP; mem_valid SHALL stay 0 for at least one cycle before any later transaction.
REQ-018 Timeout counter SHALL clear on entering BUS, increment each BUS cycle without mem_ready; at count == TIMEOUT SHALL deassert mem_valid, go to RESP with error flag set.
REQ-019 mem_ready arriving the same cycle the count reaches TIMEOUT SHALL count as success (ready wins).
REQ-020 RESP: write success sends 1 byte 0x4B ('K'); read success sends 4 bytes of captured rdata MSB first; timeout sends 1 byte 0x45 ('E').
REQ-021 Each response byte SHALL be presented with tx_valid=1 and held unchanged until a cycle with tx_ready=1; next byte (if any) presented the following cycle.
REQ-022 After last response byte accepted SHALL return to IDLE; minimum command-to-response latency 1 cycle after mem_ready.
REQ-023 mem_ready while mem_valid=0 SHALL be ignored.
REQ-024 mem_wstrb SHALL be 4'h0 whenever mem_valid is 0.

Reset
REQ-025 reset SHALL asynchronously force IDLE and all outputs to 0: mem_valid, mem_addr, mem_wdata, mem_wstrb, tx_valid, tx_byte, busy; counters and flags cleared.
REQ-026 reset mid-transaction (BUS or RESP) SHALL drop mem_valid/tx_valid immediately with no further bus or response activity; first action after release SHALL require a new command byte.

Verification
REQ-027 Write: bytes 57 00 00 10 04 DE AD BE EF, mem_ready after 3 cycles -> one bus cycle addr 0x00001004 wdata 0xDEADBEEF wstrb F, then tx byte 0x4B.
REQ-028 Read: bytes 52 00 00 20 00, mem_ready after 1 cycle with rdata 0x12345678 -> wstrb 0, tx bytes 12 34 56 78 in order.
REQ-029 Timeout: TIMEOUT=8, read command, mem_ready never asserted -> mem_valid high exactly 8 cycles, then tx byte 0x45, busy falls after acceptance.
REQ-030 Backpressure: read returning 0xA5A55A5A with tx_ready low 5 cycles per byte -> each byte held stable, no byte lost or duplicated.
REQ-031 Garbage/ignored bytes: 0xFF 0x00 in IDLE, extra bytes during BUS -> no state change, subsequent valid write completes normally.
REQ-032 Reset asserted during BUS of a write -> mem_valid 0 same cycle, no 0x4B sent, following read command completes correctly.

Source files
------------

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART command decoder driving a native memory bus.
// 'W' a3..a0 d3..d0 writes a word and replies 'K'; 'R' a3..a0 reads and replies with four bytes.
module uart_bus_master #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  localparam logic [7:0]  CMD_WRITE = 8'h57;
  localparam logic [7:0]  CMD_READ  = 8'h52;
  localparam logic [7:0]  RSP_OK    = 8'h4B;
  localparam logic [7:0]  RSP_ERR   = 8'h45;
  // The bus cycle that would make the count reach TIMEOUT is the last one.
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] tmo_q, tmo_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      tmo_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
    end
  end

  // cnt_q counts received bytes in ADDR/DATA and transmitted bytes in RESP.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 2'd0;
        if (rx_valid && rx_byte == CMD_WRITE) begin
          state_d = S_ADDR;
          write_d = 1'b1;
          err_d   = 1'b0;
        end else if (rx_valid && rx_byte == CMD_READ) begin
          state_d = S_ADDR;
          write_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d = {addr_q[23:0], rx_byte};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = write_q ? S_DATA : S_BUS;
            tmo_d   = 16'd0;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          wdata_d = {wdata_q[23:0], rx_byte};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_BUS;
            tmo_d   = 16'd0;
          end
        end
      end
      S_BUS: begin
        if (mem_ready) begin
          if (!write_q) begin
            rdata_d = mem_rdata;
          end
          err_d   = 1'b0;
          cnt_d   = 2'd0;
          state_d = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = 2'd0;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          if (err_q || write_q || cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_byte = 8'h00;
    if (state_q == S_RESP) begin
      if (err_q) begin
        tx_byte = RSP_ERR;
      end else if (write_q) begin
        tx_byte = RSP_OK;
      end else begin
        case (cnt_q)
          2'd0:    tx_byte = rdata_q[31:24];
          2'd1:    tx_byte = rdata_q[23:16];
          2'd2:    tx_byte = rdata_q[15:8];
          default: tx_byte = rdata_q[7:0];
        endcase
      end
    end
  end

  assign tx_valid  = (state_q == S_RESP);
  assign mem_valid = (state_q == S_BUS);
  assign mem_wstrb = (state_q == S_BUS && write_q) ? 4'hF : 4'h0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - self-checking bench for uart_bus_master.
module tb_uart_bus_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  uart_bus_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          bp;
    int          cycles;
    logic        err;
  } vec_t;

  int         tests = 0;
  int         failed = 0;
  int         bp = 0;
  logic [7:0] exp_q[$];
  vec_t       vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int delay, input int bpc,
                              input int cycles, input logic err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.delay = delay; v.bp = bpc; v.cycles = cycles; v.err = err;
    return v;
  endfunction

  // Transmitter model: holds tx_ready low for bp cycles of each presented byte.
  initial begin
    int wcnt;
    wcnt = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || !tx_valid) begin
        tx_ready = 1'b0;
        wcnt = 0;
      end else if (wcnt < bp) begin
        tx_ready = 1'b0;
        wcnt++;
      end else begin
        tx_ready = 1'b1;
        wcnt = 0;
      end
    end
  end

  // Scoreboard and hold checks on the response stream.
  logic       pend = 1'b0;
  logic [7:0] pend_b = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (!mem_valid) check("wstrb_idle", 32'(mem_wstrb), 32'h0);
      if (pend) begin
        check("tx_hold_valid", 32'(tx_valid), 32'h1);
        check("tx_hold_byte", 32'(tx_byte), 32'(pend_b));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL tx_unexpected actual=%h required=none", tx_byte);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(tx_byte), 32'(e));
        end
        pend = 1'b0;
      end else if (tx_valid) begin
        pend = 1'b1;
        pend_b = tx_byte;
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check(nm, 32'(busy), 32'h0);
  endtask

  task automatic wait_valid;
    int n;
    n = 0;
    while (!mem_valid && n < 10) begin
      tick();
      n++;
    end
    check("bus_start", 32'(mem_valid), 32'h1);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    if (v.err) begin
      exp_q.push_back(8'h45);
    end else if (v.wr) begin
      exp_q.push_back(8'h4B);
    end else begin
      for (int i = 0; i < 4; i++) exp_q.push_back(v.rdata[31-8*i -: 8]);
    end
    bp = v.bp;
    send(8'hFF);
    send(8'h00);
    check("idle_garbage_busy", 32'(busy), 32'h0);
    send(v.wr ? 8'h57 : 8'h52);
    check("cmd_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) send(v.addr[31-8*i -: 8]);
    if (v.wr) begin
      for (int i = 0; i < 4; i++) send(v.wdata[31-8*i -: 8]);
    end
    wait_valid();
    cyc = 0;
    while (mem_valid && cyc < 40) begin
      check("bus_addr", mem_addr, v.addr);
      check("bus_wstrb", 32'(mem_wstrb), v.wr ? 32'hF : 32'h0);
      if (v.wr) check("bus_wdata", mem_wdata, v.wdata);
      rx_byte = 8'h57;
      rx_valid = (cyc == 1);
      mem_ready = (cyc == v.delay);
      mem_rdata = (cyc == v.delay) ? v.rdata : 32'hBAD0BAD0;
      cyc++;
      tick();
    end
    rx_valid = 1'b0;
    mem_ready = 1'b0;
    check("valid_cycles", 32'(cyc), 32'(v.cycles));
    mem_ready = 1'b1;
    mem_rdata = 32'h0BADF00D;
    tick();
    mem_ready = 1'b0;
    check("no_restart", 32'(mem_valid), 32'h0);
    wait_idle("resp_done");
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    bp = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1'b1, 32'h00001004, 32'hDEADBEEF, 32'h0,        3,  0, 4, 1'b0);
    vecs[1] = mk(1'b0, 32'h00002000, 32'h0,        32'h12345678, 1,  0, 2, 1'b0);
    vecs[2] = mk(1'b0, 32'h00000000, 32'h0,        32'h77777777, 99, 0, 8, 1'b1);
    vecs[3] = mk(1'b0, 32'hCAFE0010, 32'h0,        32'hA5A55A5A, 2,  5, 3, 1'b0);
    vecs[4] = mk(1'b1, 32'hFFFFFFFC, 32'h00000000, 32'h0,        7,  2, 8, 1'b0);
    vecs[5] = mk(1'b0, 32'h01020304, 32'h0,        32'h0F1E2D3C, 7,  1, 8, 1'b0);
    vecs[6] = mk(1'b1, 32'h80000000, 32'h13579BDF, 32'h0,        8,  3, 8, 1'b1);
    vecs[7] = mk(1'b0, 32'h00000040, 32'h0,        32'h80000001, 0,  0, 1, 1'b0);

    tick();
    tick();
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_byte", 32'(tx_byte), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Reset during the bus phase of a write: nothing may be answered.
    send(8'h57);
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) send(8'h11 * 8'(i + 1));
    wait_valid();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rstbus_mem_valid", 32'(mem_valid), 32'h0);
    check("rstbus_wstrb", 32'(mem_wstrb), 32'h0);
    check("rstbus_addr", mem_addr, 32'h0);
    check("rstbus_busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b0;
    send(8'h00);
    for (int i = 0; i < 5; i++) tick();
    check("rstbus_need_cmd", 32'(busy), 32'h0);
    check("rstbus_no_tx", 32'(exp_q.size()), 32'h0);
    run_vec(vecs[1]);

    // Reset while a read response is held by backpressure.
    bp = 5;
    send(8'h52);
    for (int i = 0; i < 4; i++) send(8'h00);
    wait_valid();
    mem_ready = 1'b1;
    mem_rdata = 32'hCCDDEEFF;
    tick();
    mem_ready = 1'b0;
    check("resp_latency", 32'(tx_valid), 32'h1);
    check("resp_first", 32'(tx_byte), 32'hCC);
    tick();
    reset = 1'b1;
    #1;
    check("rstresp_tx_valid", 32'(tx_valid), 32'h0);
    check("rstresp_tx_byte", 32'(tx_byte), 32'h0);
    tick();
    reset = 1'b0;
    bp = 0;
    for (int i = 0; i < 3; i++) tick();
    check("rstresp_idle", 32'(busy), 32'h0);
    check("rstresp_quiet", 32'(tx_valid), 32'h0);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
